// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub
//   Pipelined adder/subtractor. A WIDTH-bit carry chain is cut into STAGES
//   registered segments of SEG = WIDTH/STAGES bits each. Subtraction is done
//   as a + ~b + !cin, so the operand inversion and the effective carry-in are
//   applied once, at the input. A single global enable (adv) moves the whole
//   pipeline; a stalled output freezes every stage.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   operands on a/b/cin/sub are valid
//   in_ready   block accepts operands this cycle (= !out_valid | out_ready)
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: add, 1: subtract
//   out_valid  s/cout/ovf hold a valid result
//   out_ready  downstream consumes the result this cycle
//   s          WIDTH-bit result
//   cout       carry-out; in subtract mode 1 = no borrow
//   ovf        two's-complement signed overflow
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;

  // Global pipeline enable: everything advances unless a valid result is
  // being held back by the consumer.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SEG;
    localparam int HI = (gi + 1) * SEG;

    // Operand bits still to be summed, from bit LO upwards. The inverted b
    // travels instead of b plus a mode bit, so mode needs no register.
    logic [WIDTH-1:LO] a_in;
    logic [WIDTH-1:LO] b_in;
    logic              c_in;
    logic              v_in;
    logic [SEG:0]      seg_sum;
    logic [HI-1:0]     s_next;

    // Sum bits produced so far plus this stage's carry-out and valid.
    logic [HI-1:0]     s_reg;
    logic              c_reg;
    logic              v_reg;

    assign seg_sum = {1'b0, a_in[LO +: SEG]} + {1'b0, b_in[LO +: SEG]}
                   + {{SEG{1'b0}}, c_in};

    if (gi == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b ^ {WIDTH{sub}};
      assign c_in   = cin ^ sub;
      assign v_in   = in_valid;
      assign s_next = seg_sum[SEG-1:0];
    end else begin : g_src
      assign a_in   = g_stage[gi-1].g_fwd.a_reg;
      assign b_in   = g_stage[gi-1].g_fwd.b_reg;
      assign c_in   = g_stage[gi-1].c_reg;
      assign v_in   = g_stage[gi-1].v_reg;
      assign s_next = {seg_sum[SEG-1:0], g_stage[gi-1].s_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_reg <= '0;
        c_reg <= 1'b0;
        v_reg <= 1'b0;
      end else if (adv) begin
        s_reg <= s_next;
        c_reg <= seg_sum[SEG];
        v_reg <= v_in;
      end
    end

    // Only the upper, not-yet-summed operand bits are carried forward; the
    // last stage has nothing left to forward.
    if (gi < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] a_reg;
      logic [WIDTH-1:HI] b_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= a_in[WIDTH-1:HI];
          b_reg <= b_in[WIDTH-1:HI];
        end
      end
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit (a ^ b ^ c), then
  // XORed with the carry out of the MSB.
  logic ovf_next;
  logic ovf_reg;

  assign ovf_next = g_stage[STAGES-1].a_in[WIDTH-1]
                  ^ g_stage[STAGES-1].b_in[WIDTH-1]
                  ^ g_stage[STAGES-1].seg_sum[SEG-1]
                  ^ g_stage[STAGES-1].seg_sum[SEG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (adv) begin
      ovf_reg <= ovf_next;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_reg;
  assign s         = g_stage[STAGES-1].s_reg;
  assign cout      = g_stage[STAGES-1].c_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three instances (STAGES = 4, 1, 16, WIDTH = 16)
// share one input stream; each has its own expected-result queue.
module tb_pipelined_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic        ordy;
  logic [15:0] a, b;
  logic        cin, sub;

  logic        rdy [3];
  logic        ov  [3];
  logic [15:0] so  [3];
  logic        co  [3];
  logic        of  [3];

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(16), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy), .s(so[0]),
    .cout(co[0]), .ovf(of[0]));

  pipelined_add_sub #(.WIDTH(16), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy), .s(so[1]),
    .cout(co[1]), .ovf(of[1]));

  pipelined_add_sub #(.WIDTH(16), .STAGES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(rdy[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy), .s(so[2]),
    .cout(co[2]), .ovf(of[2]));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [17:0] q [3][$];     // {cout, s, ovf}
  int          pops [3];
  int          acc  [3];

  // Integer reference: unsigned result for s/cout, signed result for ovf.
  function automatic logic [17:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                        input logic xc, input logic xs);
    int ua, ub, sa, sb, cv, r, sr;
    logic co_m, ov_m;
    ua = int'(xa);
    ub = int'(xb);
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    cv = xc ? 1 : 0;
    if (!xs) begin
      r    = ua + ub + cv;
      sr   = sa + sb + cv;
      co_m = (r > 65535);
    end else begin
      r    = ua - ub - cv;
      sr   = sa - sb - cv;
      co_m = (r >= 0);
    end
    ov_m = (sr > 32767) || (sr < -32768);
    return {co_m, r[15:0], ov_m};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Called after inputs are set, away from the clock edge. Pops/compares
  // any result being consumed, pushes any operands being accepted, then
  // advances one clock.
  task automatic cycle();
    logic [17:0] e;
    for (int d = 0; d < 3; d++) begin
      if (ov[d] && ordy) begin
        if (q[d].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output dut=%0d got=%h exp=none", d, so[d]);
        end else begin
          e = q[d].pop_front();
          pops[d]++;
          $display("txn dut=%0d s=%h cout=%b ovf=%b", d, so[d], co[d], of[d]);
          chk($sformatf("result_dut%0d", d), {14'd0, co[d], so[d], of[d]}, {14'd0, e});
        end
      end
      if (iv && rdy[d]) begin
        q[d].push_back(model(a, b, cin, sub));
        acc[d]++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // One operation into an empty pipeline with out_ready high; measures the
  // edges until out_valid on the 4-stage instance, then lets everything drain.
  task automatic latency_op(input string nm, input vec_t v);
    int lat;
    ordy = 1'b1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; iv = 1'b1;
    #1;
    chk({nm, "_in_ready"}, {31'd0, rdy[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    $display("txn %s a=%h b=%h cin=%b sub=%b -> s=%h cout=%b ovf=%b lat=%0d",
             nm, v.a, v.b, v.cin, v.sub, so[0], co[0], of[0], lat);
    chk({nm, "_latency"}, lat, 32'd4);
    chk({nm, "_s"}, {16'd0, so[0]}, {16'd0, v.s});
    chk({nm, "_cout"}, {31'd0, co[0]}, {31'd0, v.cout});
    chk({nm, "_ovf"}, {31'd0, of[0]}, {31'd0, v.ovf});
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs [6];
  int   op;
  int   start_pops;

  initial begin
    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

    for (int d = 0; d < 3; d++) begin
      pops[d] = 0;
      acc[d]  = 0;
    end

    rst_n = 1'b0; iv = 1'b0; ordy = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("reset_in_ready", {31'd0, rdy[0]}, 32'd1);
    chk("reset_s", {16'd0, so[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with latency
    for (int i = 0; i < 6; i++) latency_op($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back stream of 8 with a 3-cycle output stall
    op = 0;
    start_pops = pops[0];
    for (int c = 0; c < 30; c++) begin
      ordy = !(c >= 5 && c <= 7);
      iv   = (op < 8);
      a    = 16'(op * 16'h1111);
      b    = 16'(op * 3 + 1);
      sub  = op[0];
      cin  = op[1];
      #1;
      if (c >= 3 && c <= 9)
        chk($sformatf("stream_in_ready_c%0d", c), {31'd0, rdy[0]}, {31'd0, (c < 5 || c > 7)});
      if (c >= 5 && c <= 7) begin
        chk($sformatf("stall_out_valid_c%0d", c), {31'd0, ov[0]}, 32'd1);
        if (q[0].size() > 0)
          chk($sformatf("stall_s_stable_c%0d", c), {16'd0, so[0]}, {16'd0, q[0][0][16:1]});
      end
      if (iv && rdy[0]) op++;
      cycle();
    end
    chk("stream_result_count", pops[0] - start_pops, 32'd8);
    chk("stream_queue_empty", q[0].size(), 32'd0);

    // Reset with operations in flight
    iv = 1'b0; ordy = 1'b1;
    repeat (10) cycle();
    for (int k = 0; k < 4; k++) begin
      iv  = 1'b1;
      a   = (k == 0) ? 16'h7FFF : 16'(k * 16'h0101);
      b   = (k == 0) ? 16'h7FFF : 16'h0003;
      cin = 1'b0;
      sub = 1'b0;
      #1;
      cycle();
    end
    iv = 1'b0;
    #1;
    chk("pre_reset_out_valid", {31'd0, ov[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("async_reset_s", {16'd0, so[0]}, 32'd0);
    chk("async_reset_ovf", {31'd0, of[0]}, 32'd0);
    chk("async_reset_in_ready", {31'd0, rdy[0]}, 32'd1);
    for (int d = 0; d < 3; d++) q[d].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cycle();  // any output here would be a stale result
    latency_op("post_reset", vecs[0]);

    // Random traffic on all three depths
    for (int d = 0; d < 3; d++) acc[d] = 0;
    for (int c = 0; c < 3000; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      a    = 16'($urandom);
      b    = 16'($urandom);
      cin  = 1'($urandom);
      sub  = 1'($urandom);
      #1;
      cycle();
    end
    iv = 1'b0; ordy = 1'b1;
    #1;
    repeat (40) cycle();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("random_accepts_ge1000_dut%0d", d), {31'd0, (acc[d] >= 1000)}, 32'd1);
      chk($sformatf("random_drained_dut%0d", d), q[d].size(), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
